// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg
//   Shared definitions for the PLL lock supervisor: FSM state encoding,
//   default parameter values and a small helper used to size the cycle
//   counter.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN
    } pll_sup_state_t;

    localparam int unsigned DEF_PLL_RST_CYCLES      = 50;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 5000;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 500000;
    localparam int unsigned DEF_RELOCK_CNT_W        = 8;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// pll_sup_if
//   Signal bundle between the PLL lock supervisor and its surroundings.
//   master : the supervisor (drives PLL reset, downstream reset and status)
//   slave  : the PLL / system side (drives lock indication and error clear)
//   Signals:
//     pll_locked   PLL lock indicator, asynchronous to refclk
//     clr_err      single-cycle pulse clearing timeout_err
//     pll_rst      active-high reset to the PLL
//     sys_rst_n    active-low reset for PLL-clocked logic
//     ready        high while the supervisor is in RUN
//     relock_count saturating count of lock losses while running
//     timeout_err  sticky lock-wait timeout flag
interface pll_sup_if
    import pll_sup_pkg::*;
#(
    parameter int unsigned RELOCK_CNT_W = DEF_RELOCK_CNT_W
) ();

    logic                    pll_locked;
    logic                    clr_err;
    logic                    pll_rst;
    logic                    sys_rst_n;
    logic                    ready;
    logic [RELOCK_CNT_W-1:0] relock_count;
    logic                    timeout_err;

    modport master (
        input  pll_locked,
        input  clr_err,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output relock_count,
        output timeout_err
    );

    modport slave (
        output pll_locked,
        output clr_err,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  relock_count,
        input  timeout_err
    );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// sync_2ff
//   1-bit two-flop synchronizer with asynchronous active-low reset to 0.
//   Ports: clk, rst_n, d (asynchronous input), q (synchronized output).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Holds the PLL in reset, waits for lock, requires lock to be stable for
//   LOCK_STABLE_CYCLES before releasing sys_rst_n, and re-resets the PLL on
//   lock loss or when lock is not reached within LOCK_TIMEOUT_CYCLES.
//   Ports:
//     refclk  free-running reference clock (only clock)
//     rst_n   asynchronous active-low reset
//     bus     pll_sup_if.master (pll_locked, clr_err in; pll_rst,
//             sys_rst_n, ready, relock_count, timeout_err out)
//   Build option:
//     PLL_SUP_RELOCK_CNT_EN  when defined, relock_count is a saturating
//                            counter; otherwise it is tied to 0.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned RELOCK_CNT_W        = DEF_RELOCK_CNT_W
) (
    input  logic      refclk,
    input  logic      rst_n,
    pll_sup_if.master bus
);

    localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                           LOCK_TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    if (PLL_RST_CYCLES < 2 || LOCK_STABLE_CYCLES < 2 || LOCK_TIMEOUT_CYCLES < 2)
    begin : g_bad_param
        $error("pll_lock_supervisor: cycle parameters must be >= 2");
    end

    pll_sup_state_t          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    locked_s;
    logic                    timeout_hit;
    logic                    pll_rst_q;
    logic                    run_q;
    logic                    timeout_err_q;
    logic [RELOCK_CNT_W-1:0] relock_q;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (locked_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PLL_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        timeout_hit = 1'b0;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // lock seen in the timeout cycle still wins
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = PLL_RST;
                    timeout_hit = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s)                  state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = RUN;
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) state_d = PLL_RST;
            end
            default: state_d = PLL_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs decoded from next state so they move on the same edge as it.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_q     <= 1'b1;
            run_q         <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            pll_rst_q <= (state_d == PLL_RST);
            run_q     <= (state_d == RUN);
            if (timeout_hit)      timeout_err_q <= 1'b1;
            else if (bus.clr_err) timeout_err_q <= 1'b0;
        end
    end

`ifdef PLL_SUP_RELOCK_CNT_EN
    logic relock_evt;

    assign relock_evt = (state_q == RUN) && !locked_s;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            relock_q <= '0;
        end else if (relock_evt && (relock_q != '1)) begin
            relock_q <= relock_q + 1'b1;
        end
    end
`else
    assign relock_q = '0;
`endif

    assign bus.pll_rst      = pll_rst_q;
    assign bus.sys_rst_n    = run_q;
    assign bus.ready        = run_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Self-checking bench for pll_lock_supervisor with small cycle parameters.
//   Expected values come from the edge-timing rules of the supervisor
//   (release, lock acquire, lock loss, timeout) applied to a randomized
//   stimulus schedule, tracked as absolute refclk edge numbers.
module tb_pll_lock_supervisor;

    localparam int unsigned PRC = 4;
    localparam int unsigned LSC = 8;
    localparam int unsigned TOC = 32;
    localparam int unsigned W   = 2;

    logic refclk = 1'b0;
    logic rst_n  = 1'b1;

    pll_sup_if #(.RELOCK_CNT_W(W)) bus ();

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (PRC),
        .LOCK_STABLE_CYCLES  (LSC),
        .LOCK_TIMEOUT_CYCLES (TOC),
        .RELOCK_CNT_W        (W)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #10 refclk = ~refclk;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Loss count seen on relock_count: saturates at all-ones of W bits,
    // or stays 0 when the counter is not built.
    function automatic int exp_relock(input int losses);
        int sat;
        sat = (1 << W) - 1;
`ifdef PLL_SUP_RELOCK_CNT_EN
        return (losses > sat) ? sat : losses;
`else
        return 0;
`endif
    endfunction

    // One refclk edge; afterwards we sit 1 ns past the edge.
    task automatic step();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int e);
        while (cyc < e) step();
    endtask

    // Asynchronous reset mid-cycle, check immediate values, release just
    // after an edge so the next edge is the first one after release.
    task automatic apply_reset(input string tag);
        bus.pll_locked = 1'b0;
        bus.clr_err    = 1'b0;
        #5 rst_n = 1'b0;
        #1;
        check({tag, "_rst_pll_rst"},   bus.pll_rst,      1);
        check({tag, "_rst_sys_rst_n"}, bus.sys_rst_n,    0);
        check({tag, "_rst_ready"},     bus.ready,        0);
        check({tag, "_rst_relock"},    bus.relock_count, 0);
        check({tag, "_rst_timeout"},   bus.timeout_err,  0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    // From WAIT_LOCK: raise lock after a random delay; ready at k+LSC+2.
    task automatic lock_run(input string tag);
        int k;
        repeat ($urandom_range(0, 20)) step();
        bus.pll_locked = 1'b1;
        k = cyc + 1;
        step_to(k + LSC + 1);
        check({tag, "_ready_early"}, bus.ready, 0);
        step();
        check({tag, "_ready"},     bus.ready,     1);
        check({tag, "_sys_rst_n"}, bus.sys_rst_n, 1);
        check({tag, "_pll_rst"},   bus.pll_rst,   0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int p, q, p2, k, k2, g, len, j;

        bus.pll_locked = 1'b0;
        bus.clr_err    = 1'b0;
        step();

        // Reset release with no lock: pll_rst high for PRC edges.
        apply_reset("rel");
        for (int unsigned i = 1; i <= PRC; i++) begin
            step();
            check("rel_pll_rst", bus.pll_rst, (i < PRC) ? 1 : 0);
            check("rel_ready",   bus.ready,   0);
        end
        p = cyc;

        // Timeout, then second timeout with coincident clr_err, then clear.
        step_to(p + TOC - 1);
        check("to1_early", bus.timeout_err, 0);
        check("to1_pll_rst_low", bus.pll_rst, 0);
        step();
        check("to1_err",     bus.timeout_err, 1);
        check("to1_pll_rst", bus.pll_rst,     1);
        q = cyc;
        step_to(q + PRC - 1);
        check("to1_pulse_hi", bus.pll_rst, 1);
        step();
        check("to1_pulse_lo", bus.pll_rst, 0);
        p2 = cyc;
        step_to(p2 + TOC - 1);
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        check("to2_set_wins", bus.timeout_err, 1);
        check("to2_pll_rst",  bus.pll_rst,     1);
        repeat ($urandom_range(1, 8)) step();
        check("to2_sticky", bus.timeout_err, 1);
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        check("to2_cleared", bus.timeout_err, 0);

        // Clean lock.
        apply_reset("lock");
        step_to(cyc + PRC);
        lock_run("lock");
        check("lock_relock",  bus.relock_count, 0);
        check("lock_timeout", bus.timeout_err,  0);

        // Lock glitch during STABLE at count 5.
        apply_reset("gl");
        step_to(cyc + PRC);
        repeat ($urandom_range(0, 20)) step();
        bus.pll_locked = 1'b1;
        k = cyc + 1;
        g = k + 7;
        len = $urandom_range(1, 3);
        step_to(g - 1);
        bus.pll_locked = 1'b0;
        step_to(g - 1 + len);
        bus.pll_locked = 1'b1;
        k2 = g + len;
        step_to(k + LSC + 2);
        check("gl_no_early_ready", bus.ready, 0);
        step_to(k2 + LSC + 1);
        check("gl_ready_before", bus.ready, 0);
        step();
        check("gl_ready",     bus.ready,        1);
        check("gl_relock",    bus.relock_count, 0);

        // Five lock losses in RUN.
        apply_reset("loss");
        step_to(cyc + PRC);
        lock_run("loss0");
        for (int i = 1; i <= 5; i++) begin
            repeat ($urandom_range(1, 10)) step();
            bus.pll_locked = 1'b0;
            j = cyc + 1;
            step_to(j + 1);
            check("loss_ready_hold", bus.ready, 1);
            step();
            check("loss_ready",     bus.ready,        0);
            check("loss_sys_rst_n", bus.sys_rst_n,    0);
            check("loss_pll_rst",   bus.pll_rst,      1);
            check("loss_relock",    bus.relock_count, exp_relock(i));
            step_to(j + 1 + PRC);
            check("loss_pulse_hi", bus.pll_rst, 1);
            step();
            check("loss_pulse_lo", bus.pll_rst, 0);
            lock_run("relock");
        end
        check("loss_relock_final", bus.relock_count, exp_relock(5));

        // Reset asserted while running: immediate, no edge needed.
        apply_reset("midrun");
        step();
        check("midrun_pll_rst", bus.pll_rst, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
